// File: rtl/ro_pkg.sv
// ro_pkg: shared defaults and width helper for the readout slot mux
package ro_pkg;
  localparam int DEF_NUM_CH = 8;
  localparam int DEF_CNT_W = 17;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return (r < 1) ? 1 : r;
  endfunction
endpackage

// File: rtl/ro_slot_gen.sv
// ro_slot_gen: binary/gray slot counter with lowest-zero slot index detector
module ro_slot_gen
  import ro_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W,
  localparam int CH_W = clog2(CNT_W)
) (
  input  logic             clk,
  input  logic             rstb,
  input  logic             en,
  output logic [CNT_W-1:0] gray_count,
  output logic [CH_W-1:0]  s,
  output logic             adv
);
  logic [CNT_W-1:0] b;
  logic [CNT_W-1:0] b_nxt;
  assign b_nxt = b + CNT_W'(1);
  assign adv = en;
  // slot is the lowest zero bit of the current count; all-ones wraps to the top slot
  always_comb begin
    s = CH_W'(CNT_W - 1);
    for (int i = CNT_W - 1; i >= 0; i--) if (!b[i]) s = CH_W'(i);
  end
  // advance the count and publish its gray code on enabled edges
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      b <= '0;
      gray_count <= '0;
    end else if (en) begin
      b <= b_nxt;
      gray_count <= b_nxt ^ (b_nxt >> 1);
    end
  end
endmodule

// File: rtl/readout_slot_mux.sv
// readout_slot_mux: time-slot multiplexer of per-channel comparator events
module readout_slot_mux
  import ro_pkg::*;
#(
  parameter int NUM_CH = DEF_NUM_CH,
  parameter int CNT_W = DEF_CNT_W,
  parameter bit STICKY = 1'b1,
  localparam int CH_W = clog2(CNT_W)
) (
  input  logic              clk,
  input  logic              rstb,
  input  logic              en,
  input  logic [NUM_CH-1:0] ch_en,
  input  logic [NUM_CH-1:0] in_pol,
  input  logic [NUM_CH-1:0] in_pol_eve,
  output logic [CNT_W-1:0]  gray_count,
  output logic              out_valid,
  output logic [CH_W-1:0]   out_ch,
  output logic              out_pol,
  output logic              out_pol_eve,
  output logic              ovf
);
  logic [CH_W-1:0] s;
  logic adv;
  logic valid;
  logic ovf_set;
  logic [NUM_CH-1:0] ev_pol;
  logic [NUM_CH-1:0] ev_eve;
  logic [NUM_CH-1:0] slot_hit;
  logic [NUM_CH-1:0] clr;
  logic [CNT_W-1:0] en_x;
  logic [CNT_W-1:0] pol_x;
  logic [CNT_W-1:0] eve_x;
  logic [CNT_W-1:0] ev_pol_x;
  logic [CNT_W-1:0] ev_eve_x;
  ro_slot_gen #(.CNT_W(CNT_W)) u_gen (
    .clk(clk),
    .rstb(rstb),
    .en(en),
    .gray_count(gray_count),
    .s(s),
    .adv(adv)
  );
  for (genvar k = 0; k < NUM_CH; k++) begin : g_hit
    assign slot_hit[k] = adv && (s == CH_W'(k));
  end
  assign clr = slot_hit & ch_en;
  assign en_x = CNT_W'(ch_en);
  assign pol_x = CNT_W'(in_pol);
  assign eve_x = CNT_W'(in_pol_eve);
  assign ev_pol_x = CNT_W'(ev_pol);
  assign ev_eve_x = CNT_W'(ev_eve);
  assign valid = adv && en_x[s];
  assign ovf_set = |(((in_pol & ev_pol) | (in_pol_eve & ev_eve)) & ~slot_hit);
  if (STICKY) begin : g_sticky
    // latch enabled events until their channel's reported slot consumes them
    always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
        ev_pol <= '0;
        ev_eve <= '0;
      end else begin
        ev_pol <= (ev_pol | (in_pol & ch_en)) & ~clr;
        ev_eve <= (ev_eve | (in_pol_eve & ch_en)) & ~clr;
      end
    end
  end else begin : g_live
    assign ev_pol = '0;
    assign ev_eve = '0;
  end
  // register the selected channel's data and the sticky overrun flag
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      out_valid <= 1'b0;
      out_ch <= '0;
      out_pol <= 1'b0;
      out_pol_eve <= 1'b0;
      ovf <= 1'b0;
    end else begin
      out_valid <= valid;
      out_pol <= valid && (pol_x[s] || ev_pol_x[s]);
      out_pol_eve <= valid && (eve_x[s] || ev_eve_x[s]);
      if (adv) out_ch <= s;
      ovf <= ovf || ovf_set;
    end
  end
endmodule

// File: tb/tb_readout_slot_mux.sv
// tb_readout_slot_mux: directed and random checks of sticky and live slot muxes
module tb_readout_slot_mux;
  localparam int CNT_W = 4;
  localparam int NUM_CH = 3;
  logic clk = 1'b0;
  logic rstb = 1'b0;
  logic en = 1'b0;
  logic [2:0] ch_en = '0;
  logic [2:0] in_pol = '0;
  logic [2:0] in_pol_eve = '0;
  logic [3:0] g1, g0;
  logic [1:0] c1, c0;
  logic v1, p1, e1, o1, v0, p0, e0, o0;
  int n_assert = 0;
  int n_fail = 0;
  int cnt, m_gray, m_valid, m_ch, m_pol, m_eve, m_pol0, m_eve0, m_ovf;
  bit pend_pol [NUM_CH];
  bit pend_eve [NUM_CH];

  readout_slot_mux #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .STICKY(1'b1)) dut (
    .clk(clk), .rstb(rstb), .en(en), .ch_en(ch_en), .in_pol(in_pol),
    .in_pol_eve(in_pol_eve), .gray_count(g1), .out_valid(v1), .out_ch(c1),
    .out_pol(p1), .out_pol_eve(e1), .ovf(o1)
  );
  readout_slot_mux #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .STICKY(1'b0)) dut0 (
    .clk(clk), .rstb(rstb), .en(en), .ch_en(ch_en), .in_pol(in_pol),
    .in_pol_eve(in_pol_eve), .gray_count(g0), .out_valid(v0), .out_ch(c0),
    .out_pol(p0), .out_pol_eve(e0), .ovf(o0)
  );

  always #5 clk = ~clk;

  function automatic int slot_of(input int b);
    int s;
    s = 0;
    while (s < CNT_W - 1 && ((b >> s) & 1) == 1) s++;
    return s;
  endfunction

  task automatic chk(input string tag, input int got, input int exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    cnt = 0; m_gray = 0; m_valid = 0; m_ch = 0; m_pol = 0; m_eve = 0;
    m_pol0 = 0; m_eve0 = 0; m_ovf = 0;
    for (int k = 0; k < NUM_CH; k++) begin
      pend_pol[k] = 0;
      pend_eve[k] = 0;
    end
  endtask

  task automatic model_edge();
    int s;
    bit ok;
    s = slot_of(cnt);
    ok = en && s < NUM_CH && ch_en[s % NUM_CH];
    m_valid = ok;
    if (en) m_ch = s;
    m_pol = ok && (pend_pol[s % NUM_CH] || in_pol[s % NUM_CH]);
    m_eve = ok && (pend_eve[s % NUM_CH] || in_pol_eve[s % NUM_CH]);
    m_pol0 = ok && in_pol[s % NUM_CH];
    m_eve0 = ok && in_pol_eve[s % NUM_CH];
    for (int k = 0; k < NUM_CH; k++) begin
      bit here;
      here = en && s == k;
      if (!here && ((in_pol[k] && pend_pol[k]) || (in_pol_eve[k] && pend_eve[k]))) m_ovf = 1;
      if (here && ch_en[k]) begin
        pend_pol[k] = 0;
        pend_eve[k] = 0;
      end else if (ch_en[k]) begin
        if (in_pol[k]) pend_pol[k] = 1;
        if (in_pol_eve[k]) pend_eve[k] = 1;
      end
    end
    if (en) cnt = (cnt + 1) % (1 << CNT_W);
    m_gray = cnt ^ (cnt >> 1);
  endtask

  task automatic check_all();
    chk("gray", int'(g1), m_gray);
    chk("valid", int'(v1), m_valid);
    chk("ch", int'(c1), m_ch);
    chk("pol", int'(p1), m_pol);
    chk("eve", int'(e1), m_eve);
    chk("ovf", int'(o1), m_ovf);
    chk("live_gray", int'(g0), m_gray);
    chk("live_valid", int'(v0), m_valid);
    chk("live_ch", int'(c0), m_ch);
    chk("live_pol", int'(p0), m_pol0);
    chk("live_eve", int'(e0), m_eve0);
    chk("live_ovf", int'(o0), 0);
  endtask

  task automatic do_reset();
    rstb = 1'b0;
    #2;
    model_reset();
    check_all();
    rstb = 1'b1;
  endtask

  task automatic step(input logic e, input logic [2:0] ce, input logic [2:0] p, input logic [2:0] q);
    en = e;
    ch_en = ce;
    in_pol = p;
    in_pol_eve = q;
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  initial begin
    do_reset();
    for (int i = 1; i <= 32; i++) begin
      step(1'b1, 3'b111, 3'b000, 3'b000);
      if (i == 8) begin
        chk("seq_c8_ch", int'(c1), 3);
        chk("seq_c8_valid", int'(v1), 0);
      end
      if (i == 4) chk("seq_c4_gray", int'(g1), 4'b0110);
    end
    @(negedge clk);
    do_reset();
    for (int i = 1; i <= 16; i++) begin
      step(1'b1, 3'b111, (i == 1) ? 3'b100 : 3'b000, 3'b000);
      if (i == 4) begin
        chk("sticky_c4_pol", int'(p1), 1);
        chk("live_c4_pol", int'(p0), 0);
      end
      if (i == 12) begin
        chk("sticky_c12_ch", int'(c1), 2);
        chk("sticky_c12_pol", int'(p1), 0);
      end
    end
    @(negedge clk);
    do_reset();
    for (int i = 1; i <= 20; i++) step(1'b1, 3'b111, 3'b010, 3'b000);
    chk("held_ovf", int'(o1), 1);
    @(negedge clk);
    do_reset();
    for (int i = 1; i <= 16; i++) step(1'b1, 3'b110, {2'b00, 1'(i % 2)}, 3'b000);
    for (int i = 1; i <= 8; i++) step(1'b1, 3'b111, {2'b00, 1'(i % 3 == 0)}, 3'b001);
    @(negedge clk);
    do_reset();
    for (int i = 1; i <= 6; i++) step(1'b1, 3'b111, 3'b000, 3'b000);
    for (int i = 1; i <= 5; i++) begin
      step(1'b0, 3'b111, (i == 2) ? 3'b010 : 3'b000, 3'b000);
      chk("hold_gray", int'(g1), 4'b0101);
    end
    for (int i = 1; i <= 6; i++) step(1'b1, 3'b111, 3'b000, 3'b000);
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 79) == 0) begin
        @(negedge clk);
        do_reset();
      end
      step($urandom_range(0, 5) != 0, 3'($urandom),
           ($urandom_range(0, 2) == 0) ? 3'($urandom) : 3'b000,
           ($urandom_range(0, 2) == 0) ? 3'($urandom) : 3'b000);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
